xpb_table_gen: RTL

- Programmable, sequential replacement for the fixed constant xpb ROMs used by the modular-squaring reduction path.
- On request, builds the table entry[j] = (j * BASE) mod MOD, j = 0..2^SEL_W-1, into an internal register file: one entry per cycle, by repeated modular addition.
- Once built, serves NUM_LANES independent lookups per cycle with 1-cycle registered latency.
- Lets one bitstream serve any modulus or reduction position without regenerating constant tables.

---
 rtl/xpb_table_gen_if.sv | 46 ++++
 rtl/xpb_table_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/xpb_table_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : xpb_table_gen_if
// Description : Control/lookup bundle for the programmable xpb table
//               generator. The master side (requester) drives the init
//               operands and lookup indices. The slave side (table) returns
//               status and per-lane lookup data.
//   init_start  : pulse, latch base_in/mod_in and (re)build the table
//   base_in     : multiplicand constant, must be < mod_in
//   mod_in      : nonzero modulus
//   init_busy   : generation in progress
//   init_done   : one-cycle pulse when the table becomes valid
//   table_ready : table valid, lookups are served
//   lk_valid    : lookup request for all lanes
//   lk_sel      : lane k index at [k*SEL_W +: SEL_W]
//   lk_out_valid: registered lookup response valid
//   lk_data     : lane k entry at [k*DATA_W +: DATA_W]
// Revision    : 1.0 - initial release
// ============================================================================
interface xpb_table_gen_if #(
  parameter int DATA_W    = 1024,
  parameter int SEL_W     = 5,
  parameter int NUM_LANES = 2
);
  logic                          init_start;
  logic [DATA_W-1:0]             base_in;
  logic [DATA_W-1:0]             mod_in;
  logic                          init_busy;
  logic                          init_done;
  logic                          table_ready;
  logic                          lk_valid;
  logic [NUM_LANES*SEL_W-1:0]    lk_sel;
  logic                          lk_out_valid;
  logic [NUM_LANES*DATA_W-1:0]   lk_data;

  modport master (
    output init_start, base_in, mod_in, lk_valid, lk_sel,
    input  init_busy, init_done, table_ready, lk_out_valid, lk_data
  );

  modport slave (
    input  init_start, base_in, mod_in, lk_valid, lk_sel,
    output init_busy, init_done, table_ready, lk_out_valid, lk_data
  );
endinterface
`default_nettype wire

// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : xpb_table_gen
// Description : Builds entry[j] = (j * BASE) mod MOD for j = 0..2^SEL_W-1 into
//               an internal register file, one entry per cycle by repeated
//               modular addition. Then it serves NUM_LANES independent
//               lookups per cycle with one cycle of registered latency.
// Ports       :
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : xpb_table_gen_if slave modport (init operands, status, lookups)
// Revision    : 1.0 - initial release
// ============================================================================
module xpb_table_gen #(
  parameter int DATA_W    = 1024,
  parameter int SEL_W     = 5,
  parameter int NUM_LANES = 2
) (
  input wire logic       clk,
  input wire logic       rst_n,
  xpb_table_gen_if.slave bus
);

  localparam int c_DEPTH = 1 << SEL_W;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GEN   = 2'd1;
  localparam logic [1:0] c_READY = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;

  logic [DATA_W-1:0] r_base;
  logic [DATA_W-1:0] r_mod;
  logic [DATA_W-1:0] r_acc;
  logic [SEL_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_table [c_DEPTH];

  logic              r_busy;
  logic              r_done;
  logic              r_ready;
  logic              r_lk_valid;
  logic              w_busy_d;
  logic              w_done_d;
  logic              w_ready_d;

  logic              w_start;
  logic              w_last;
  logic              w_we;
  logic [SEL_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W:0]   w_sum;
  logic              w_wrap;
  logic [DATA_W-1:0] w_nxt;
  logic              w_lk_fire;

  // A start request is honoured from IDLE or READY. During GEN it is ignored
  // so the latched operands stay coherent with the partially built table.
  assign w_start = bus.init_start && (r_state != c_GEN);
  assign w_last  = (r_idx == {SEL_W{1'b1}});

  // acc and base are both < mod, so one conditional subtraction is enough.
  // The carry bit takes part only in the compare. The subtraction is exact
  // modulo 2^DATA_W because the true result already lies in [0, mod).
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_base};
  assign w_wrap = (w_sum >= {1'b0, r_mod});
  assign w_nxt  = w_sum[DATA_W-1:0] - (w_wrap ? r_mod : '0);

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (bus.init_start) w_next_state = c_GEN;
      c_GEN:   if (w_last)         w_next_state = c_READY;
      c_READY: if (bus.init_start) w_next_state = c_GEN;
      default:                     w_next_state = c_IDLE;
    endcase
  end

  // Status flags are registered from the current state, so they trail it by
  // one cycle. The exception is table_ready: it drops on the same edge that
  // accepts a re-init, so no lookup is accepted against a half-rebuilt table.
  always_comb begin
    w_busy_d  = (r_state == c_GEN);
    w_ready_d = (r_state == c_READY) && !bus.init_start;
    w_done_d  = w_ready_d && !r_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_ready <= w_ready_d;
    end
  end

  // ----------------------------------------------------------- datapath ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_start) begin
      r_base <= bus.base_in;
      r_mod  <= bus.mod_in;
      r_acc  <= '0;
      r_idx  <= SEL_W'(1);
    end else if (r_state == c_GEN) begin
      r_acc  <= w_nxt;
      r_idx  <= r_idx + SEL_W'(1);
    end
  end

  // Single write port: entry[0] = 0 on the start edge, then one entry per
  // GEN cycle.
  assign w_we    = rst_n && (w_start || (r_state == c_GEN));
  assign w_waddr = w_start ? '0 : r_idx;
  assign w_wdata = w_start ? '0 : w_nxt;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_table[w_waddr] <= w_wdata;
    end
  end

  // ------------------------------------------------------------ lookups ----
  // Reads sample the table before this edge's write. A lookup that coincides
  // with a re-init therefore still returns the old contents.
  assign w_lk_fire = bus.lk_valid && r_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lk_valid <= 1'b0;
    end else begin
      r_lk_valid <= w_lk_fire;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [SEL_W-1:0]  w_sel;
    logic [DATA_W-1:0] r_data;

    assign w_sel = bus.lk_sel[g*SEL_W +: SEL_W];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_data <= '0;
      end else if (w_lk_fire) begin
        r_data <= r_table[w_sel];
      end
    end

    assign bus.lk_data[g*DATA_W +: DATA_W] = r_data;
  end

  assign bus.init_busy    = r_busy;
  assign bus.init_done    = r_done;
  assign bus.table_ready  = r_ready;
  assign bus.lk_out_valid = r_lk_valid;

endmodule
`default_nettype wire
